// File: rtl/svi_cas_pkg.sv
// -----------------------------------------------------------------------------
// svi_cas_pkg
// Shared definitions for the cassette FSK player: the player state encoding
// (which doubles as the externally visible status code), the byte frame
// length and the number of half periods that make up each bit value.
// -----------------------------------------------------------------------------
package svi_cas_pkg;

  // Encoding is the status code seen on status_o.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_END    = 3'd4
  } cas_state_e;

  localparam int FRAME_BITS = 11;  // start + 8 data + 2 stop
  localparam int HALFS_BIT0 = 2;   // half periods of the low tone per "0"
  localparam int HALFS_BIT1 = 4;   // half periods of the high tone per "1"

  // Frame is shifted out LSB first: start 0, d0..d7, stop 1, stop 1.
  function automatic logic [10:0] make_frame(input logic [7:0] data);
    return {2'b11, data, 1'b0};
  endfunction

endpackage

// File: rtl/svi_cas_fsk_tone_gen.sv
// -----------------------------------------------------------------------------
// cas_tone_gen
// FSK bit generator. Produces one bit of tone at a time: a "0" is two half
// periods of HALF_P0 cycles, a "1" is four half periods of HALF_P1 cycles.
// The level is 1 at every bit start and toggles at each half-period end.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   clr_i            : hold at the start of a bit (level 1, counters 0)
//   run_i            : advance one cycle
//   bit_i            : value of the bit being played, stable for the bit
//   tone_o           : tone level
//   bit_done_o       : pulse in the last cycle of the current bit
// -----------------------------------------------------------------------------
module cas_tone_gen
  import svi_cas_pkg::*;
#(
  parameter int HALF_P0 = 8888,
  parameter int HALF_P1 = 4444
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clr_i,
  input  logic run_i,
  input  logic bit_i,
  output logic tone_o,
  output logic bit_done_o
);

  localparam int HMAX = (HALF_P0 > HALF_P1) ? HALF_P0 : HALF_P1;
  localparam int CW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    half_q, half_d;
  logic          tone_q, tone_d;
  logic [CW-1:0] half_last;
  logic [1:0]    halfs_last;
  logic          half_end;

  always_comb begin
    half_last  = bit_i ? CW'(HALF_P1 - 1) : CW'(HALF_P0 - 1);
    halfs_last = bit_i ? 2'(HALFS_BIT1 - 1) : 2'(HALFS_BIT0 - 1);
    half_end   = run_i && !clr_i && (cnt_q == half_last);
    bit_done_o = half_end && (half_q == halfs_last);

    cnt_d  = cnt_q;
    half_d = half_q;
    tone_d = tone_q;
    if (clr_i) begin
      cnt_d  = '0;
      half_d = '0;
      tone_d = 1'b1;
    end else if (run_i) begin
      if (half_end) begin
        // Even number of toggles per bit, so the level is back at 1 when
        // the next bit starts.
        cnt_d  = '0;
        tone_d = ~tone_q;
        half_d = bit_done_o ? 2'd0 : half_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      half_q <= '0;
      tone_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/svi_cas_fsk.sv
// -----------------------------------------------------------------------------
// svi_cas_fsk
// Plays a cassette image from SDRAM as an FSK tape signal: a leader of "1"
// bits, then each byte framed as start/8 data/2 stop, with a one-byte
// prefetch buffer in front of the shifter.
// Ports:
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   play_i             : motor on (level)
//   rewind_i           : synchronous restart to byte 0
//   len_i              : image length in bytes, sampled when leaving IDLE
//   mem_addr_o/mem_rd_o: byte read request, held until mem_ready_i
//   mem_avail_i        : SDRAM slot free this cycle
//   mem_ready_i/data_i : read completion pulse and data
//   tape_o             : FSK output
//   status_o           : 0 IDLE, 1 LEADER, 2 DATA, 3 PAUSED, 4 END
// -----------------------------------------------------------------------------
module svi_cas_fsk
  import svi_cas_pkg::*;
#(
  parameter int HALF_P0     = 8888,
  parameter int HALF_P1     = 4444,
  parameter int LEADER_BITS = 1600
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        play_i,
  input  logic        rewind_i,
  input  logic [20:0] len_i,
  output logic [20:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic        mem_avail_i,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  output logic        tape_o,
  output logic [2:0]  status_o
);

  localparam int LW = (LEADER_BITS > 1) ? $clog2(LEADER_BITS) : 1;

  cas_state_e    state_q, state_d, resume_q, resume_d;
  logic [20:0]   len_q, len_d, addr_q, addr_d;
  logic          rd_q, rd_d, discard_q, discard_d, buf_full_q, buf_full_d;
  logic [7:0]    buf_q, buf_d;
  logic [10:0]   frame_q, frame_d;
  logic [3:0]    bits_left_q, bits_left_d;
  logic [LW-1:0] leader_cnt_q, leader_cnt_d;

  logic       running, cur_bit, tone, bit_done, accept, byte_ready;
  logic [7:0] next_byte;

  assign running = (state_q == ST_LEADER) || (state_q == ST_DATA);
  // bits_left_q == 0 in DATA means mark fill while waiting for a byte.
  assign cur_bit = (state_q == ST_DATA && bits_left_q != 4'd0) ? frame_q[0] : 1'b1;

  cas_tone_gen #(
    .HALF_P0(HALF_P0),
    .HALF_P1(HALF_P1)
  ) u_tone (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (!running),
    .run_i     (play_i),
    .bit_i     (cur_bit),
    .tone_o    (tone),
    .bit_done_o(bit_done)
  );

  assign accept     = mem_ready_i && rd_q;
  // A byte arriving in the same cycle as a frame-end bypasses the buffer.
  assign byte_ready = buf_full_q || accept;
  assign next_byte  = buf_full_q ? buf_q : mem_data_i;

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    len_d        = len_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    discard_d    = discard_q;
    buf_full_d   = buf_full_q;
    buf_d        = buf_q;
    frame_d      = frame_q;
    bits_left_d  = bits_left_q;
    leader_cnt_d = leader_cnt_q;

    // Prefetch side. A stale completion left over from a rewind is eaten
    // here, and no new request starts until it has arrived.
    if (accept) begin
      buf_d      = mem_data_i;
      buf_full_d = 1'b1;
      addr_d     = addr_q + 21'd1;
      rd_d       = 1'b0;
    end else if (!rd_q && !buf_full_q && !discard_q && running &&
                 mem_avail_i && (addr_q < len_q)) begin
      rd_d = 1'b1;
    end
    if (mem_ready_i && !rd_q) discard_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (play_i && len_i != 21'd0) begin
          state_d      = ST_LEADER;
          len_d        = len_i;
          leader_cnt_d = '0;
          bits_left_d  = 4'd0;
        end
      end
      ST_LEADER, ST_DATA: begin
        if (!play_i) begin
          state_d  = ST_PAUSED;
          resume_d = state_q;
        end else if (bit_done) begin
          if (state_q == ST_LEADER && leader_cnt_q != LW'(LEADER_BITS - 1)) begin
            leader_cnt_d = leader_cnt_q + LW'(1);
          end else if (state_q == ST_DATA && bits_left_q > 4'd1) begin
            frame_d     = frame_q >> 1;
            bits_left_d = bits_left_q - 4'd1;
          end else begin
            // Bit boundary outside a frame: start a frame, finish, or fill
            // with a mark bit.
            state_d = ST_DATA;
            if (byte_ready) begin
              frame_d     = make_frame(next_byte);
              bits_left_d = 4'(FRAME_BITS);
              buf_full_d  = 1'b0;
            end else if (addr_q == len_q) begin
              state_d = ST_END;
            end else begin
              bits_left_d = 4'd0;
            end
          end
        end
      end
      ST_PAUSED: begin
        if (play_i) state_d = resume_q;
      end
      default: ;
    endcase

    if (rewind_i) begin
      state_d      = ST_IDLE;
      addr_d       = '0;
      buf_full_d   = 1'b0;
      rd_d         = 1'b0;
      leader_cnt_d = '0;
      bits_left_d  = 4'd0;
      // A completion in this very cycle closes the request; otherwise the
      // next one belongs to the abandoned read.
      discard_d    = (rd_q || discard_q) && !mem_ready_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      resume_q     <= ST_LEADER;
      len_q        <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      discard_q    <= 1'b0;
      buf_full_q   <= 1'b0;
      buf_q        <= '0;
      frame_q      <= '0;
      bits_left_q  <= '0;
      leader_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      discard_q    <= discard_d;
      buf_full_q   <= buf_full_d;
      buf_q        <= buf_d;
      frame_q      <= frame_d;
      bits_left_q  <= bits_left_d;
      leader_cnt_q <= leader_cnt_d;
    end
  end

  assign tape_o     = running && tone;
  assign mem_addr_o = addr_q;
  assign mem_rd_o   = rd_q;
  assign status_o   = state_q;

endmodule

// File: tb/tb_svi_cas_fsk.sv
// -----------------------------------------------------------------------------
// tb_svi_cas_fsk
// Directed bench for svi_cas_fsk with HALF_P0=4, HALF_P1=2, LEADER_BITS=2,
// so every bit lasts 8 cycles: "1" = 11001100, "0" = 11110000.
// A responder process answers each read 3 cycles after mem_rd_o rises.
// -----------------------------------------------------------------------------
module tb_svi_cas_fsk;

  logic        clk = 1'b0;
  logic        reset_n, play, rewind, mem_avail, mem_ready, tape, mem_rd;
  logic [20:0] len, mem_addr;
  logic [7:0]  mem_data;
  logic [2:0]  status;

  logic [7:0]  image [0:1];
  int          hold;
  int          vec  = 0;
  int          miss = 0;

  always #5 clk = ~clk;

  svi_cas_fsk #(
    .HALF_P0(4),
    .HALF_P1(2),
    .LEADER_BITS(2)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .play_i     (play),
    .rewind_i   (rewind),
    .len_i      (len),
    .mem_addr_o (mem_addr),
    .mem_rd_o   (mem_rd),
    .mem_avail_i(mem_avail),
    .mem_ready_i(mem_ready),
    .mem_data_i (mem_data),
    .tape_o     (tape),
    .status_o   (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples one 8-cycle bit; returns 1, 0, or -1 for a malformed bit.
  task automatic get_bit(output int b);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = {s[6:0], tape};
    end
    if (s == 8'b11001100) b = 1;
    else if (s == 8'b11110000) b = 0;
    else b = -1;
  endtask

  task automatic expect_bit(input int e, input string tag);
    int b;
    get_bit(b);
    chk(tag, b, e);
  endtask

  task automatic expect_frame(input logic [7:0] d, input string tag);
    expect_bit(0, {tag, "_start"});
    for (int i = 0; i < 8; i++) expect_bit(int'(d[i]), $sformatf("%s_d%0d", tag, i));
    expect_bit(1, {tag, "_stop0"});
    expect_bit(1, {tag, "_stop1"});
  endtask

  task automatic do_rewind();
    play = 1'b0;
    @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = mem_rd;
    end
    chk(tag, seen, 1'b1);
  endtask

  // Memory responder: ready pulse 3 cycles after the request rises,
  // optionally followed by a stretch with the SDRAM slot unavailable.
  initial begin
    logic [20:0] a;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        a = mem_addr;
        repeat (2) @(negedge clk);
        mem_data  = image[a[0]];
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        if (hold > 0) begin
          mem_avail = 1'b0;
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rd_while_unavail", mem_rd, 1'b0);
          end
          mem_avail = 1'b1;
          hold = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int marks;
    reset_n = 1'b0; play = 1'b0; rewind = 1'b0; len = '0;
    mem_avail = 1'b1; mem_ready = 1'b0; mem_data = '0; hold = 0;
    image[0] = 8'hA5; image[1] = 8'h81;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset, motor off.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outs", {tape, mem_rd, mem_addr, status}, 32'd0);
    end

    // One byte 0xA5: leader 1,1 then frame, then END.
    len = 21'd1; play = 1'b1;
    expect_bit(1, "a5_lead0");
    expect_bit(1, "a5_lead1");
    expect_frame(8'hA5, "a5");
    @(negedge clk);
    chk("a5_end_status", status, 3'd4);
    chk("a5_end_tape", tape, 1'b0);
    chk("a5_end_addr", mem_addr, 21'd1);
    repeat (10) @(negedge clk);
    chk("a5_end_hold", {status, tape}, {3'd4, 1'b0});

    // Pause at cycle 3 of the start bit, then the bit replays in full.
    do_rewind();
    chk("rew_status", status, 3'd0);
    chk("rew_addr", mem_addr, 21'd0);
    play = 1'b1;
    expect_bit(1, "p_lead0");
    expect_bit(1, "p_lead1");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p_start_head", tape, 1'b1);
    end
    play = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("p_paused", {status, tape}, {3'd3, 1'b0});
    end
    play = 1'b1;
    expect_frame(8'hA5, "p");
    @(negedge clk);
    chk("p_end_status", status, 3'd4);

    // Two bytes with SDRAM unavailable for 200 cycles after byte 1:
    // 13 mark bits, the second byte arriving right on a bit boundary.
    do_rewind();
    image[0] = 8'h3C; image[1] = 8'h81;
    len = 21'd2; hold = 200; play = 1'b1;
    expect_bit(1, "u_lead0");
    expect_bit(1, "u_lead1");
    expect_frame(8'h3C, "u_b1");
    marks = 0;
    b = 1;
    for (int i = 0; i < 40 && b == 1; i++) begin
      get_bit(b);
      if (b == 1) marks++;
    end
    chk("u_marks", marks, 13);
    chk("u_b2_start", b, 0);
    for (int i = 0; i < 8; i++) expect_bit(int'(image[1][i]), $sformatf("u_b2_d%0d", i));
    expect_bit(1, "u_b2_stop0");
    expect_bit(1, "u_b2_stop1");
    @(negedge clk);
    chk("u_end", {status, tape}, {3'd4, 1'b0});
    chk("u_end_addr", mem_addr, 21'd2);

    // Rewind with a read pending: request drops, late ready discarded.
    do_rewind();
    image[0] = 8'hA5;
    play = 1'b1;
    wait_rd("rw_rd_seen");
    rewind = 1'b1; play = 1'b0;
    @(negedge clk);
    rewind = 1'b0;
    chk("rw_rd_drop", mem_rd, 1'b0);
    chk("rw_addr0", mem_addr, 21'd0);
    chk("rw_idle", status, 3'd0);
    repeat (4) @(negedge clk);
    chk("rw_discard_addr", mem_addr, 21'd0);
    chk("rw_discard_rd", mem_rd, 1'b0);
    play = 1'b1;
    expect_bit(1, "rw_lead0");
    expect_bit(1, "rw_lead1");
    expect_frame(8'hA5, "rw");
    do_rewind();

    // Zero length never leaves IDLE.
    len = 21'd0; play = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("zero_len", {status, mem_rd}, 4'd0);
    end
    play = 1'b0;

    // Reset in the middle of a read; the late ready is ignored.
    len = 21'd1; play = 1'b1;
    wait_rd("rst_rd_seen");
    reset_n = 1'b0;
    #1;
    chk("rst_async", {tape, mem_rd, mem_addr, status}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; play = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready_ignored", {mem_rd, mem_addr}, 22'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/svi_cas_fsk.md
SVI_CAS_FSK -- requirements
Module: svi_cas_fsk

Interface
REQ-001 Parameter HALF_P0, default 8888, clk_i cycles per half period of the 1200 Hz "0" tone.
REQ-002 Parameter HALF_P1, default 4444, clk_i cycles per half period of the 2400 Hz "1" tone.
REQ-003 Parameter LEADER_BITS, default 1600, number of "1" bits emitted before the first data byte.
REQ-004 clk_i  in  1  the single clock, the 21.3 MHz cassette clock.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 play_i  in  1  tape motor on; level-sensitive.
REQ-007 rewind_i  in  1  synchronous restart to byte 0.
REQ-008 len_i  in  21  image length in bytes.
REQ-009 mem_addr_o  out  21  byte address within the CAS area of SDRAM.
REQ-010 mem_rd_o  out  1  read request.
REQ-011 mem_avail_i  in  1  SDRAM slot free, e.g. CPU refresh.
REQ-012 mem_ready_i  in  1  one-cycle pulse; mem_data_i valid.
REQ-013 mem_data_i  in  8  read data.
REQ-014 tape_o  out  1  FSK tape signal to the console tape input.
REQ-015 status_o  out  3  0 IDLE, 1 LEADER, 2 DATA, 3 PAUSED, 4 END.

Function
REQ-016 The block SHALL sample len_i when it leaves IDLE and SHALL ignore len_i otherwise.
REQ-017 In IDLE with play_i=1 and len_i!=0 the block SHALL enter LEADER. With len_i=0 it SHALL stay in IDLE.
REQ-018 LEADER SHALL emit exactly LEADER_BITS "1" bits and then enter DATA.
REQ-019 Bit "0" SHALL be 2 half periods of HALF_P0 cycles; bit "1" SHALL be 4 half periods of HALF_P1 cycles.
REQ-020 tape_o SHALL be 1 at every bit start and SHALL toggle at the end of each half period.
REQ-021 Byte frame SHALL be: start 0, d0..d7 LSB first, stop 1, stop 1 (11 bits).
REQ-022 A one-byte prefetch buffer SHALL be used. mem_rd_o SHALL rise only when all of the following hold: buffer empty, mem_addr_o<len, state is LEADER or DATA, mem_avail_i=1.
REQ-023 mem_rd_o SHALL stay high until mem_ready_i. On that edge the block SHALL capture the buffer, increment mem_addr_o by 1 and drop mem_rd_o.
REQ-024 mem_ready_i without a pending read SHALL be ignored.
REQ-025 At frame end the next frame SHALL load from a full buffer. If the buffer is empty (underrun), the block SHALL emit "1" bits until a byte is available, never a partial bit.
REQ-026 When mem_addr_o=len, the buffer is empty and the last stop bit has ended, the block SHALL enter END, drive tape_o=0, and stay in END until rewind.
REQ-027 play_i=0 in LEADER or DATA SHALL enter PAUSED: counters frozen, tape_o=0, pending read still completed.
REQ-028 play_i=1 in PAUSED SHALL resume the interrupted bit from its beginning, in the prior state.
REQ-029 rewind_i SHALL have the highest priority: state IDLE, mem_addr_o=0, buffer empty, tape_o=0, leader counter cleared.
REQ-030 Rewind with a read pending SHALL drop mem_rd_o next cycle, and the next mem_ready_i SHALL be discarded.
REQ-031 Simultaneous mem_ready_i and a frame-end load SHALL move the new byte straight to the shifter, leaving the buffer empty.

Reset
REQ-032 Reset SHALL set: state IDLE, status_o=0, tape_o=0, mem_rd_o=0, mem_addr_o=0, buffer empty, all counters 0, discard flag 0.
REQ-033 Reset mid-read SHALL abandon the request without waiting for mem_ready_i.

Structure
REQ-034 Package svi_cas_pkg SHALL hold the state/status enum, the frame length (11) and the half-period counts per bit (2, 4).
REQ-035 Sub-module cas_tone_gen SHALL hold the half-period counter, the toggle and the bit-done pulse, with HALF_P0/HALF_P1 as parameters.

Verification
All scenarios use HALF_P0=4, HALF_P1=2, LEADER_BITS=2.
REQ-036 Release reset with play_i=0 -> all outputs 0 and status_o=0 for 100 cycles.
REQ-037 len=1, data 0xA5, mem_avail_i=1, ready 3 cycles after rd -> bits 1,1 then 0,1,0,1,0,0,1,0,1,1,1, each 8 cycles, then status_o=4 and tape_o=0.
REQ-038 len=2, mem_avail_i=0 for 200 cycles after byte 1 -> mem_rd_o stays low, mark bits are inserted after the frame, then byte 2 is framed intact.
REQ-039 play_i low at cycle 3 of a "0" bit for 50 cycles -> status_o=3, tape_o=0, then that bit replays in full 8 cycles.
REQ-040 rewind_i while mem_rd_o=1 -> mem_rd_o=0 next cycle, the next ready is dropped, and mem_addr_o=0.
REQ-041 len_i=0 with play_i=1 -> status_o stays 0 and mem_rd_o is never asserted.
